muldiv_ctrl: RTL

Iterative multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU from the EX stage and runs a 32-iteration shift-add or restoring-divide sequence. It writes HI/LO on completion and drives the decode-stage stall that interlocks MFHI/MFLO and back-to-back multiply/divide instructions. It also handles MTHI/MTLO writes.

---
 rtl/mips_md_pkg.sv | 29 ++
 rtl/muldiv_core.sv | 106 ++++++++++
 rtl/muldiv_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mips_md_pkg.sv
// Encodings, state enum and constants shared by the HI/LO multiply/divide sequencer.
package mips_md_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      MUL  = 2'b01,
      DIV  = 2'b10,
      FIX  = 2'b11
   } md_state_e;

   localparam int unsigned MD_ITERS   = 32;
   localparam logic [31:0] MD_DIV0_LO = 32'hFFFF_FFFF;

   function automatic logic [31:0] md_mag(input logic [31:0] v, input logic neg);
      if (neg) begin
         return ~v + 32'd1;
      end else begin
         return v;
      end
   endfunction

endpackage

// File: rtl/muldiv_core.sv
// Datapath for the sequencer: shift-add accumulator, restoring divider and
// final two's-complement sign correction, driven by strobes from muldiv_ctrl.
module muldiv_core
   import mips_md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             step_mul_i,
   input  logic             step_div_i,
   input  logic             fix_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] res_hi_o,
   output logic [WIDTH-1:0] res_lo_o
);

   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   rem_q;
   logic [WIDTH-1:0]   quo_q;
   logic [WIDTH-1:0]   m_q;
   logic               is_div_q;
   logic               neg_prod_q;
   logic               neg_quo_q;
   logic               neg_rem_q;
   logic               div0_q;

   logic               sgn_op_s;
   logic               sa_s;
   logic               sb_s;
   logic [WIDTH:0]     sum_s;
   logic [WIDTH:0]     rsh_s;
   logic               q_bit_s;
   logic [2*WIDTH-1:0] prod_fix_s;
   logic [WIDTH-1:0]   quo_fix_s;
   logic [WIDTH-1:0]   rem_fix_s;

   assign sgn_op_s = (op_i == MD_MULT) || (op_i == MD_DIV);
   assign sa_s     = sgn_op_s & a_i[WIDTH-1];
   assign sb_s     = sgn_op_s & b_i[WIDTH-1];

   // Multiplier bits shift out of the low half while partial sums enter the top.
   assign sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
   assign rsh_s   = {rem_q, quo_q[WIDTH-1]};
   assign q_bit_s = (rsh_s >= {1'b0, m_q});

   // Operand latch and one iteration per strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q      <= {(2*WIDTH){1'b0}};
         rem_q      <= {WIDTH{1'b0}};
         quo_q      <= {WIDTH{1'b0}};
         m_q        <= {WIDTH{1'b0}};
         is_div_q   <= 1'b0;
         neg_prod_q <= 1'b0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div0_q     <= 1'b0;
      end else if (load_i) begin
         is_div_q   <= op_i[1];
         neg_prod_q <= sa_s ^ sb_s;
         neg_quo_q  <= sa_s ^ sb_s;
         neg_rem_q  <= sa_s;
         div0_q     <= (b_i == {WIDTH{1'b0}});
         rem_q      <= {WIDTH{1'b0}};
         if (op_i[1]) begin
            m_q   <= md_mag(b_i, sb_s);
            quo_q <= md_mag(a_i, sa_s);
            acc_q <= {(2*WIDTH){1'b0}};
         end else begin
            m_q   <= md_mag(a_i, sa_s);
            acc_q <= {{WIDTH{1'b0}}, md_mag(b_i, sb_s)};
            quo_q <= {WIDTH{1'b0}};
         end
      end else if (step_mul_i) begin
         acc_q <= {sum_s, acc_q[WIDTH-1:1]};
      end else if (step_div_i) begin
         rem_q <= q_bit_s ? (rsh_s[WIDTH-1:0] - m_q) : rsh_s[WIDTH-1:0];
         quo_q <= {quo_q[WIDTH-2:0], q_bit_s};
      end
   end

   assign prod_fix_s = neg_prod_q ? (-acc_q) : acc_q;
   assign quo_fix_s  = neg_quo_q ? (-quo_q) : quo_q;
   assign rem_fix_s  = neg_rem_q ? (-rem_q) : rem_q;

   // Corrected result, presented only while the FSM is in FIX.
   always_comb begin
      res_hi_o = {WIDTH{1'b0}};
      res_lo_o = {WIDTH{1'b0}};
      if (!fix_i) begin
         res_hi_o = {WIDTH{1'b0}};
         res_lo_o = {WIDTH{1'b0}};
      end else if (is_div_q) begin
         res_hi_o = rem_fix_s;
         res_lo_o = div0_q ? MD_DIV0_LO : quo_fix_s;
      end else begin
         res_hi_o = prod_fix_s[2*WIDTH-1:WIDTH];
         res_lo_o = prod_fix_s[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, runs the 32-iteration FSM and
// generates the decode-stage interlock for MFHI/MFLO and back-to-back ops.
module muldiv_ctrl
   import mips_md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_E,
   input  logic [1:0]       op_E,
   input  logic [WIDTH-1:0] src_a_E,
   input  logic [WIDTH-1:0] src_b_E,
   input  logic             mt_hi_E,
   input  logic             mt_lo_E,
   input  logic             mf_req_D,
   input  logic             md_req_D,
   output logic             stall_D,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [4:0] LAST_ITER = 5'(MD_ITERS - 1);

   md_state_e        state_q, state_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             load_s;
   logic             step_mul_s;
   logic             step_div_s;
   logic             fix_s;
   logic [WIDTH-1:0] res_hi_s;
   logic [WIDTH-1:0] res_lo_s;

   muldiv_core #(.WIDTH(WIDTH)) u_core (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load_s),
      .step_mul_i (step_mul_s),
      .step_div_i (step_div_s),
      .fix_i      (fix_s),
      .op_i       (op_E),
      .a_i        (src_a_E),
      .b_i        (src_b_E),
      .res_hi_o   (res_hi_s),
      .res_lo_o   (res_lo_s)
   );

   // State, counter and architectural register updates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         hi_q    <= {WIDTH{1'b0}};
         lo_q    <= {WIDTH{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic and datapath strobes.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      load_s     = 1'b0;
      step_mul_s = 1'b0;
      step_div_s = 1'b0;
      fix_s      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_E) begin
               load_s  = 1'b1;
               cnt_d   = 5'd0;
               state_d = op_E[1] ? DIV : MUL;
            end else begin
               state_d = IDLE;
            end
         end
         MUL: begin
            step_mul_s = 1'b1;
            cnt_d      = cnt_q + 5'd1;
            if (cnt_q == LAST_ITER) begin
               state_d = FIX;
            end else begin
               state_d = MUL;
            end
         end
         DIV: begin
            step_div_s = 1'b1;
            cnt_d      = cnt_q + 5'd1;
            if (cnt_q == LAST_ITER) begin
               state_d = FIX;
            end else begin
               state_d = DIV;
            end
         end
         FIX: begin
            fix_s   = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // MTHI/MTLO only land when the unit is idle and not being started.
   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      busy_d = (state_d != IDLE);
      done_d = (state_q == FIX);
      if (state_q == FIX) begin
         hi_d = res_hi_s;
         lo_d = res_lo_s;
      end else if ((state_q == IDLE) && !start_E) begin
         hi_d = mt_hi_E ? src_a_E : hi_q;
         lo_d = mt_lo_E ? src_a_E : lo_q;
      end else begin
         hi_d = hi_q;
         lo_d = lo_q;
      end
   end

   assign stall_D = ~rst & (busy_q | start_E) & (mf_req_D | md_req_D);
   assign busy    = busy_q;
   assign done    = done_q;
   assign hi      = hi_q;
   assign lo      = lo_q;

endmodule
